// File: rtl/pb_press_classifier.sv
// Push-button gesture classifier: turns debounced press/release pulses into
// short-press, double-click and long-press events, with auto-repeat while a
// long press is held.
module pb_press_classifier #(
  parameter int LONG_CYCLES   = 50,
  parameter int DOUBLE_GAP    = 20,
  parameter int REPEAT_CYCLES = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic PB_pressed_pulse,
  input  logic PB_released_pulse,
  output logic short_pulse,
  output logic double_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic busy
);

  localparam int MAX_AB = (LONG_CYCLES > DOUBLE_GAP) ? LONG_CYCLES : DOUBLE_GAP;
  localparam int MAX_T  = (MAX_AB > REPEAT_CYCLES) ? MAX_AB : REPEAT_CYCLES;
  localparam int TW     = $clog2(MAX_T) + 1;

  localparam logic [TW-1:0] LONG_LAST   = TW'(LONG_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST    = TW'(DOUBLE_GAP - 1);
  localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    HELD1,
    GAP,
    HELD2,
    LONG_HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q;
  logic            wrap;
  logic            short_d, double_d, long_d, repeat_d;

  // Next-state and pulse decode; release takes priority in held states,
  // press takes priority in IDLE/GAP, so at most one pulse per cycle.
  always_comb begin
    state_d  = state_q;
    wrap     = 1'b0;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (PB_pressed_pulse) state_d = HELD1;
      end
      HELD1: begin
        if (PB_released_pulse) begin
          state_d = GAP;
        end else if (timer_q == LONG_LAST) begin
          state_d = LONG_HOLD;
          long_d  = 1'b1;
        end
      end
      GAP: begin
        if (PB_pressed_pulse) begin
          state_d = HELD2;
        end else if (timer_q == GAP_LAST) begin
          state_d = IDLE;
          short_d = 1'b1;
        end
      end
      HELD2: begin
        if (PB_released_pulse) begin
          state_d  = IDLE;
          double_d = 1'b1;
        end
      end
      LONG_HOLD: begin
        if (PB_released_pulse) begin
          state_d = IDLE;
        end else if (timer_q == REPEAT_LAST) begin
          repeat_d = 1'b1;
          wrap     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, saturating timer (cleared on state change or repeat wrap) and
  // registered one-cycle output pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      short_pulse  <= 1'b0;
      double_pulse <= 1'b0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q || wrap) begin
        timer_q <= '0;
      end else if (timer_q != '1) begin
        timer_q <= timer_q + TW'(1);
      end
      short_pulse  <= short_d;
      double_pulse <= double_d;
      long_pulse   <= long_d;
      repeat_pulse <= repeat_d;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_pb_press_classifier.sv
// Directed self-checking bench for pb_press_classifier (default parameters).
// Edge index e counts rising edges from the start of each scenario; inputs
// are set before edge e and outputs are sampled 1 ns after it.
module tb_pb_press_classifier;

  logic clk = 1'b0;
  logic rst;
  logic pb_p, pb_r;
  logic short_pulse, double_pulse, long_pulse, repeat_pulse, busy;

  int checks = 0;
  int fails  = 0;

  localparam logic [3:0] P_NONE   = 4'b0000;
  localparam logic [3:0] P_SHORT  = 4'b1000;
  localparam logic [3:0] P_DOUBLE = 4'b0100;
  localparam logic [3:0] P_LONG   = 4'b0010;
  localparam logic [3:0] P_REPEAT = 4'b0001;

  pb_press_classifier #(
    .LONG_CYCLES  (50),
    .DOUBLE_GAP   (20),
    .REPEAT_CYCLES(10)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .PB_pressed_pulse (pb_p),
    .PB_released_pulse(pb_r),
    .short_pulse      (short_pulse),
    .double_pulse     (double_pulse),
    .long_pulse       (long_pulse),
    .repeat_pulse     (repeat_pulse),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] pulses();
    return {short_pulse, double_pulse, long_pulse, repeat_pulse};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    pb_p = 1'b0;
    pb_r = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; pb_p = 1'b1; pb_r = 1'b0;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk); #1;
      checks++;
      if (pulses() !== P_NONE || busy !== 1'b0) begin
        fails++;
        $display("FAIL reset e=%0d pulses=%b busy=%b expected pulses=0000 busy=0", e, pulses(), busy);
      end
    end
    rst = 1'b0; pb_p = 1'b0;
    tick();
  endtask

  task automatic test_short();
    logic [3:0] exp;
    for (int e = 0; e <= 40; e++) begin
      pb_p = (e == 0);
      pb_r = (e == 10);
      tick();
      exp = (e == 30) ? P_SHORT : P_NONE;
      checks++;
      if (pulses() !== exp || busy !== (e < 30)) begin
        fails++;
        $display("FAIL short e=%0d pulses=%b busy=%b expected pulses=%b busy=%b", e, pulses(), busy, exp, (e < 30));
      end
    end
  endtask

  task automatic test_double();
    logic [3:0] exp;
    for (int e = 0; e <= 45; e++) begin
      pb_p = (e == 0) || (e == 13);
      pb_r = (e == 5) || (e == 18);
      tick();
      exp = (e == 18) ? P_DOUBLE : P_NONE;
      checks++;
      if (pulses() !== exp || busy !== (e < 18)) begin
        fails++;
        $display("FAIL double e=%0d pulses=%b busy=%b expected pulses=%b busy=%b", e, pulses(), busy, exp, (e < 18));
      end
    end
  endtask

  task automatic test_long();
    logic [3:0] exp;
    for (int e = 0; e <= 115; e++) begin
      pb_p = (e == 0);
      pb_r = (e == 101);
      tick();
      if (e == 50) exp = P_LONG;
      else if (e == 60 || e == 70 || e == 80 || e == 90 || e == 100) exp = P_REPEAT;
      else exp = P_NONE;
      checks++;
      if (pulses() !== exp || busy !== (e < 101)) begin
        fails++;
        $display("FAIL long e=%0d pulses=%b busy=%b expected pulses=%b busy=%b", e, pulses(), busy, exp, (e < 101));
      end
    end
  endtask

  task automatic test_long_boundary();
    logic [3:0] exp;
    for (int e = 0; e <= 80; e++) begin
      pb_p = (e == 0);
      pb_r = (e == 50);
      tick();
      exp = (e == 70) ? P_SHORT : P_NONE;
      checks++;
      if (pulses() !== exp || busy !== (e < 70)) begin
        fails++;
        $display("FAIL long_boundary e=%0d pulses=%b busy=%b expected pulses=%b busy=%b", e, pulses(), busy, exp, (e < 70));
      end
    end
  endtask

  task automatic test_gap_boundary();
    logic [3:0] exp;
    for (int e = 0; e <= 55; e++) begin
      pb_p = (e == 0) || (e == 25);
      pb_r = (e == 5) || (e == 30);
      tick();
      exp = (e == 30) ? P_DOUBLE : P_NONE;
      checks++;
      if (pulses() !== exp || busy !== (e < 30)) begin
        fails++;
        $display("FAIL gap_boundary e=%0d pulses=%b busy=%b expected pulses=%b busy=%b", e, pulses(), busy, exp, (e < 30));
      end
    end
  endtask

  task automatic test_reset_mid_gap();
    for (int e = 0; e <= 40; e++) begin
      pb_p = (e == 0) || (e == 10);
      pb_r = (e == 5);
      rst  = (e == 10) || (e == 11);
      tick();
      checks++;
      if (pulses() !== P_NONE || busy !== (e < 10)) begin
        fails++;
        $display("FAIL reset_mid_gap e=%0d pulses=%b busy=%b expected pulses=0000 busy=%b", e, pulses(), busy, (e < 10));
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_idle_release();
    for (int e = 0; e <= 5; e++) begin
      pb_r = (e == 0) || (e == 2);
      tick();
      checks++;
      if (pulses() !== P_NONE || busy !== 1'b0) begin
        fails++;
        $display("FAIL idle_release e=%0d pulses=%b busy=%b expected pulses=0000 busy=0", e, pulses(), busy);
      end
    end
  endtask

  // Both inputs together: IDLE->HELD1 (press), HELD1->GAP (release),
  // GAP->HELD2 (press), HELD2->IDLE with double_pulse (release).
  task automatic test_both_inputs();
    logic [3:0] exp;
    for (int e = 0; e <= 35; e++) begin
      pb_p = (e == 0) || (e == 3) || (e == 6) || (e == 8);
      pb_r = pb_p;
      tick();
      exp = (e == 8) ? P_DOUBLE : P_NONE;
      checks++;
      if (pulses() !== exp || busy !== (e < 8)) begin
        fails++;
        $display("FAIL both_inputs e=%0d pulses=%b busy=%b expected pulses=%b busy=%b", e, pulses(), busy, exp, (e < 8));
      end
    end
  endtask

  initial begin
    rst = 1'b1; pb_p = 1'b0; pb_r = 1'b0;
    test_reset();
    test_short();
    test_double();
    test_long();
    test_long_boundary();
    test_gap_boundary();
    test_reset_mid_gap();
    test_idle_release();
    test_both_inputs();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
